// File: rtl/gdp_pkg.sv
// Shared definitions for the GDP datapath: width default, op codes and ALU FSM states.
package gdp_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        OP_PASS_A = 3'b000,
        OP_ADD    = 3'b001,
        OP_SUB    = 3'b010,
        OP_AND    = 3'b011,
        OP_OR     = 3'b100,
        OP_XOR    = 3'b101,
        OP_SHL_A  = 3'b110,
        OP_MUL    = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/gdp_shift_add_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle over WIDTH cycles.
module gdp_shift_add_mul
    import gdp_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 done_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;
    logic [2*WIDTH-1:0] acc_d;

    // Accumulate the current partial product.
    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Iteration registers: load on start, then step while running.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_q <= '0;
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Final product is valid during the last iteration, ahead of its edge.
    assign product_o = acc_d;
    assign done_o    = run_q && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/gdp_alu.sv
// GDP ALU: captures an operation on start, executes it (single-cycle ops or
// iterative multiply) and presents registered result/flags with a done pulse.
module gdp_alu
    import gdp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry_flag,
    output logic                  zero_flag,
    output logic                  busy,
    output logic                  done
);

    state_e                  state_q, state_d;
    logic [2:0]              op_q;
    logic [DATA_WIDTH-1:0]   a_q, b_q;
    logic                    exec_settle_q;
    logic                    mul_start_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    carry_q, zero_q;

    logic [DATA_WIDTH:0]     sum_s;
    logic [DATA_WIDTH-1:0]   alu_res_s;
    logic                    alu_carry_s;
    logic [2*DATA_WIDTH-1:0] mul_prod_s;
    logic                    mul_done_s;

    gdp_shift_add_mul #(.WIDTH(DATA_WIDTH)) u_mul (
        .clk_i     (clock),
        .rst_i     (reset),
        .start_i   (mul_start_q),
        .a_i       (a_q),
        .b_i       (b_q),
        .product_o (mul_prod_s),
        .done_o    (mul_done_s)
    );

    assign sum_s = {1'b0, a_q} + {1'b0, b_q};

    // Single-cycle operations on the captured operands.
    always_comb begin
        alu_res_s   = a_q;
        alu_carry_s = 1'b0;
        case (op_q)
            OP_PASS_A: alu_res_s = a_q;
            OP_ADD:    {alu_carry_s, alu_res_s} = sum_s;
            OP_SUB: begin
                alu_res_s   = a_q - b_q;
                alu_carry_s = (a_q < b_q);
            end
            OP_AND:    alu_res_s = a_q & b_q;
            OP_OR:     alu_res_s = a_q | b_q;
            OP_XOR:    alu_res_s = a_q ^ b_q;
            OP_SHL_A: begin
                alu_res_s   = {a_q[DATA_WIDTH-2:0], 1'b0};
                alu_carry_s = a_q[DATA_WIDTH-1];
            end
            default: begin
                alu_res_s   = a_q;
                alu_carry_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; EXEC holds for one settle cycle before write-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (op == OP_MUL) ? ST_MUL : ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = exec_settle_q ? ST_DONE : ST_EXEC;
            ST_MUL:  state_d = mul_done_s ? ST_DONE : ST_MUL;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy = (state_q == ST_EXEC) || (state_q == ST_MUL);
        done = (state_q == ST_DONE);
    end

    // Operation capture and multiplier launch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q          <= 3'b000;
            a_q           <= '0;
            b_q           <= '0;
            mul_start_q   <= 1'b0;
            exec_settle_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                op_q <= op;
                a_q  <= operand_A;
                b_q  <= operand_B;
            end
            mul_start_q   <= (state_q == ST_IDLE) && start && (op == OP_MUL);
            exec_settle_q <= (state_q == ST_EXEC) && !exec_settle_q;
        end
    end

    // Result and flags change only at a completion edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else if ((state_q == ST_EXEC) && exec_settle_q) begin
            result_q <= alu_res_s;
            carry_q  <= alu_carry_s;
            zero_q   <= (alu_res_s == '0);
        end else if ((state_q == ST_MUL) && mul_done_s) begin
            result_q <= mul_prod_s[DATA_WIDTH-1:0];
            carry_q  <= |mul_prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            zero_q   <= (mul_prod_s[DATA_WIDTH-1:0] == '0);
        end
    end

    assign result     = result_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

endmodule

// File: tb/tb_gdp_alu.sv
// Self-checking bench for gdp_alu: directed cases plus randomized ops against a
// behavioural arithmetic model, timing of done/busy, reset abort and register-file use.
module tb_gdp_alu;

    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [DW-1:0] operand_A, operand_B;
    logic [DW-1:0] result;
    logic          carry_flag, zero_flag, busy, done;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    gdp_alu #(.DATA_WIDTH(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .operand_A  (operand_A),
        .operand_B  (operand_B),
        .result     (result),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Reference: returns {zero, carry, result} from plain integer arithmetic.
    function automatic logic [DW+1:0] model(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint ua, ub, r, m;
        logic c;
        ua = longint'(a); ub = longint'(b); m = longint'(1) << DW; c = 1'b0; r = 0;
        case (o)
            3'd0: r = ua;
            3'd1: begin r = ua + ub; c = (r >= m); r = r % m; end
            3'd2: begin c = (ua < ub); r = (ua - ub + m) % m; end
            3'd3: r = longint'(a & b);
            3'd4: r = longint'(a | b);
            3'd5: r = longint'(a ^ b);
            3'd6: begin r = (ua * 2) % m; c = (ua >= m / 2); end
            default: begin r = ua * ub; c = (r >= m); r = r % m; end
        endcase
        return {(r == 0), c, DW'(r)};
    endfunction

    // Issue one operation and observe it until one sample after done (bounded).
    task automatic run_op(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit hold, input bit scramble,
                          output logic [DW-1:0] res, output logic cf, output logic zf,
                          output int done_off, output int busy_cnt, output int done_cnt);
        done_off = -1; busy_cnt = 0; done_cnt = 0;
        @(negedge clock);
        start = 1'b1; op = o; operand_A = a; operand_B = b;
        @(posedge clock); #1;
        if (!hold) start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_off < 0) done_off = i;
                start = 1'b0;
            end
            if (done_off >= 0 && i > done_off) break;
            if (scramble) begin
                operand_A = DW'($urandom); operand_B = DW'($urandom); op = 3'($urandom);
            end
            @(posedge clock); #1;
        end
        start = 1'b0;
        res = result; cf = carry_flag; zf = zero_flag;
    endtask

    logic [DW-1:0] r_s;
    logic          c_s, z_s;
    int            doff, bcnt, dcnt;

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'd0; operand_A = '0; operand_B = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_cnt++; if (result !== 8'h00) $display("FAIL reset_result got=%h exp=00", result); else pass_cnt++;
        chk_cnt++; if ({carry_flag, zero_flag} !== 2'b00) $display("FAIL reset_flags got=%b exp=00", {carry_flag, zero_flag}); else pass_cnt++;
        chk_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); else pass_cnt++;
        @(negedge clock); reset = 1'b0;
    endtask

    task automatic test_add();
        run_op(3'd1, 8'hF0, 8'h20, 1'b0, 1'b0, r_s, c_s, z_s, doff, bcnt, dcnt);
        chk_cnt++; if ({z_s, c_s, r_s} !== {1'b0, 1'b1, 8'h10}) $display("FAIL add_f0_20 got z=%b c=%b r=%h exp z=0 c=1 r=10", z_s, c_s, r_s); else pass_cnt++;
        chk_cnt++; if (doff !== 2) $display("FAIL add_done_latency got=%0d exp=2", doff); else pass_cnt++;
        chk_cnt++; if (dcnt !== 1) $display("FAIL add_done_width got=%0d exp=1", dcnt); else pass_cnt++;
    endtask

    task automatic test_sub();
        run_op(3'd2, 8'h05, 8'h05, 1'b0, 1'b0, r_s, c_s, z_s, doff, bcnt, dcnt);
        chk_cnt++; if ({z_s, c_s, r_s} !== {1'b1, 1'b0, 8'h00}) $display("FAIL sub_eq got z=%b c=%b r=%h exp z=1 c=0 r=00", z_s, c_s, r_s); else pass_cnt++;
        run_op(3'd2, 8'h03, 8'h04, 1'b0, 1'b0, r_s, c_s, z_s, doff, bcnt, dcnt);
        chk_cnt++; if ({z_s, c_s, r_s} !== {1'b0, 1'b1, 8'hFF}) $display("FAIL sub_borrow got z=%b c=%b r=%h exp z=0 c=1 r=ff", z_s, c_s, r_s); else pass_cnt++;
    endtask

    task automatic test_mul();
        run_op(3'd7, 8'd13, 8'd11, 1'b0, 1'b0, r_s, c_s, z_s, doff, bcnt, dcnt);
        chk_cnt++; if ({z_s, c_s, r_s} !== {1'b0, 1'b0, 8'h8F}) $display("FAIL mul_13_11 got z=%b c=%b r=%h exp z=0 c=0 r=8f", z_s, c_s, r_s); else pass_cnt++;
        chk_cnt++; if (bcnt !== DW + 1) $display("FAIL mul_busy_cycles got=%0d exp=%0d", bcnt, DW + 1); else pass_cnt++;
        chk_cnt++; if (doff !== DW + 1) $display("FAIL mul_done_latency got=%0d exp=%0d", doff, DW + 1); else pass_cnt++;
        run_op(3'd7, 8'h10, 8'h10, 1'b0, 1'b0, r_s, c_s, z_s, doff, bcnt, dcnt);
        chk_cnt++; if ({z_s, c_s, r_s} !== {1'b1, 1'b1, 8'h00}) $display("FAIL mul_overflow got z=%b c=%b r=%h exp z=1 c=1 r=00", z_s, c_s, r_s); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [2:0]    o;
        logic [DW-1:0] a, b;
        logic [DW+1:0] exp_v;
        for (int n = 0; n < 48; n++) begin
            o = (n < 16) ? 3'(n % 8) : 3'($urandom);
            a = DW'($urandom); b = DW'($urandom);
            if (n % 8 == 3) b = a;
            exp_v = model(o, a, b);
            run_op(o, a, b, 1'b0, 1'b0, r_s, c_s, z_s, doff, bcnt, dcnt);
            chk_cnt++;
            if ({z_s, c_s, r_s} !== exp_v)
                $display("FAIL rand_op%0d a=%h b=%h got zcr=%b_%b_%h exp zcr=%b_%b_%h", o, a, b, z_s, c_s, r_s, exp_v[DW+1], exp_v[DW], exp_v[DW-1:0]);
            else pass_cnt++;
            chk_cnt++;
            if (doff !== ((o == 3'd7) ? DW + 1 : 2) || dcnt !== 1)
                $display("FAIL rand_timing op%0d got off=%0d pulses=%0d", o, doff, dcnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored();
        run_op(3'd7, 8'd13, 8'd11, 1'b1, 1'b1, r_s, c_s, z_s, doff, bcnt, dcnt);
        chk_cnt++; if (r_s !== 8'h8F || c_s !== 1'b0) $display("FAIL start_ignored_result got c=%b r=%h exp c=0 r=8f", c_s, r_s); else pass_cnt++;
        chk_cnt++; if (dcnt !== 1 || doff !== DW + 1) $display("FAIL start_ignored_pulses got pulses=%0d off=%0d exp 1,%0d", dcnt, doff, DW + 1); else pass_cnt++;
    endtask

    task automatic test_hold();
        logic [DW-1:0] prev;
        run_op(3'd6, 8'hC3, 8'h00, 1'b0, 1'b0, r_s, c_s, z_s, doff, bcnt, dcnt);
        prev = r_s;
        operand_A = 8'h11; operand_B = 8'h22; op = 3'd1;
        repeat (5) @(posedge clock);
        #1;
        chk_cnt++; if ({zero_flag, carry_flag, result} !== {1'b0, 1'b1, 8'h86} || result !== prev)
            $display("FAIL hold_idle got z=%b c=%b r=%h exp z=0 c=1 r=86", zero_flag, carry_flag, result); else pass_cnt++;
    endtask

    task automatic test_reset_mid_mul();
        run_op(3'd1, 8'h01, 8'h02, 1'b0, 1'b0, r_s, c_s, z_s, doff, bcnt, dcnt);
        chk_cnt++; if (r_s !== 8'h03) $display("FAIL pre_reset_add got=%h exp=03", r_s); else pass_cnt++;
        @(negedge clock);
        start = 1'b1; op = 3'd7; operand_A = 8'hFF; operand_B = 8'hFF;
        @(posedge clock); #1; start = 1'b0;
        repeat (5) @(posedge clock);
        #2; reset = 1'b1; #1;
        chk_cnt++; if ({busy, done} !== 2'b00) $display("FAIL midmul_reset_status got=%b exp=00", {busy, done}); else pass_cnt++;
        chk_cnt++; if ({result, carry_flag, zero_flag} !== 10'd0) $display("FAIL midmul_reset_result got r=%h c=%b z=%b exp 0", result, carry_flag, zero_flag); else pass_cnt++;
        @(negedge clock); reset = 1'b0;
        run_op(3'd1, 8'h01, 8'h01, 1'b0, 1'b0, r_s, c_s, z_s, doff, bcnt, dcnt);
        chk_cnt++; if (r_s !== 8'h02 || doff !== 2) $display("FAIL post_reset_add got r=%h off=%0d exp r=02 off=2", r_s, doff); else pass_cnt++;
    endtask

    task automatic test_regfile();
        logic [DW-1:0] rf [4];
        logic [DW-1:0] wb;
        bit            sel_alu;
        rf[0] = 8'h07; rf[1] = 8'h06; rf[2] = 8'h00; rf[3] = 8'h00;
        run_op(3'd7, rf[0], rf[1], 1'b0, 1'b0, r_s, c_s, z_s, doff, bcnt, dcnt);
        sel_alu = 1'b1;
        wb = sel_alu ? result : 8'h00;
        rf[2] = wb;
        chk_cnt++; if (rf[2] !== 8'h2A) $display("FAIL regfile_wb_r2 got=%h exp=2a", rf[2]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_random();
        test_start_ignored();
        test_hold();
        test_reset_mid_mul();
        test_regfile();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
